barcodescanner_nios_video_scanout: RTL

Display-side reader for the dual-port VideoRAM. The block owns the RAM's second port (`s2`) as a read-only master. It fetches a 320×240, 1-bit-per-pixel frame buffer (10 words per row, 2400 words from `BASE_ADDR`) and scans it out as a 640×480@60 VGA stream. Each pixel is doubled horizontally and vertically. The Nios keeps port 1 for writing the barcode/preview image.

---
 rtl/barcodescanner_nios_video_scanout_pkg.sv | 32 +++
 rtl/barcodescanner_nios_video_scanout_vga_timing.sv | 52 +++++
 rtl/barcodescanner_nios_video_scanout.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/barcodescanner_nios_video_scanout_pkg.sv
// Shared constants for the VideoRAM scanout: default VGA 640x480@60 timing,
// counter/bus widths and a sync-window helper.
package barcodescanner_nios_video_scanout_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
    localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

    localparam int RGB_W      = 24;
    localparam int CNT_W      = 10;
    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 32;
    localparam int WORD_CLKS  = 64;  // 32 bits, each shown for two clocks
    localparam int FETCH_LEAD = 4;

    function automatic logic in_window(input logic [CNT_W-1:0] c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction

endpackage

// File: rtl/barcodescanner_nios_video_scanout_vga_timing.sv
// Free-running h/v raster counters with raw (unregistered) sync and
// visible-area flags derived from them.
module barcodescanner_nios_vga_timing
    import barcodescanner_nios_video_scanout_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             line_end,
    output logic             frame_end,
    output logic             hs,
    output logic             vs,
    output logic             visible
);

    localparam int LINE_CLKS   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START    = H_ACTIVE + H_FP;
    localparam int HS_END      = HS_START + H_SYNC;
    localparam int VS_START    = V_ACTIVE + V_FP;
    localparam int VS_END      = VS_START + V_SYNC;

    assign line_end  = (h_cnt == CNT_W'(LINE_CLKS - 1));
    assign frame_end = line_end && (v_cnt == CNT_W'(FRAME_LINES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign hs      = in_window(h_cnt, HS_START, HS_END);
    assign vs      = in_window(v_cnt, VS_START, VS_END);
    assign visible = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));

endmodule

// File: rtl/barcodescanner_nios_video_scanout.sv
// Reads a 1bpp frame buffer through VideoRAM port 2 and scans it out as
// pixel-doubled VGA; all video outputs share one register stage.
module barcodescanner_nios_video_scanout
    import barcodescanner_nios_video_scanout_pkg::*;
#(
    parameter int               BASE_ADDR     = 0,
    parameter int               WORDS_PER_ROW = 10,
    parameter int               SRC_ROWS      = 240,
    parameter int               H_ACTIVE      = H_ACTIVE_DEF,
    parameter int               H_FP          = H_FP_DEF,
    parameter int               H_SYNC        = H_SYNC_DEF,
    parameter int               H_BP          = H_BP_DEF,
    parameter int               V_ACTIVE      = V_ACTIVE_DEF,
    parameter int               V_FP          = V_FP_DEF,
    parameter int               V_SYNC        = V_SYNC_DEF,
    parameter int               V_BP          = V_BP_DEF,
    parameter logic [RGB_W-1:0] FG_RGB        = 24'hFFFFFF,
    parameter logic [RGB_W-1:0] BG_RGB        = 24'h000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              invert,
    output logic [ADDR_W-1:0] address2,
    output logic              chipselect2,
    output logic              clken2,
    output logic              write2,
    output logic [3:0]        byteenable2,
    output logic [DATA_W-1:0] writedata2,
    input  logic [DATA_W-1:0] readdata2,
    output logic              vga_hs_n,
    output logic              vga_vs_n,
    output logic              vga_blank_n,
    output logic [RGB_W-1:0]  vga_rgb,
    output logic              frame_start
);

    localparam int LINE_CLKS   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FETCH_LINES = (2 * SRC_ROWS < V_ACTIVE) ? 2 * SRC_ROWS : V_ACTIVE;

    logic [CNT_W-1:0]  h_cnt, v_cnt, v_next;
    logic              line_end, frame_end, hs, vs, visible;
    logic              frame_en, frame_inv;
    logic [ADDR_W-1:0] row_base, next_row_base;
    logic [DATA_W-1:0] next_word, shift_reg, pix_src;
    logic              capture, last_line, row_step, load_word, pix_bit, show;
    logic [CNT_W:0]    h_ahead;
    logic              word0_issue, wordk_issue, fetch_req;
    logic [ADDR_W-1:0] fetch_addr;

    barcodescanner_nios_vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk       (clk),
        .reset_n   (reset_n),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .line_end  (line_end),
        .frame_end (frame_end),
        .hs        (hs),
        .vs        (vs),
        .visible   (visible)
    );

    assign clken2      = 1'b1;
    assign write2      = 1'b0;
    assign byteenable2 = 4'hF;
    assign writedata2  = '0;

    // Word 0 of a line is fetched on the previous line, so it must use the
    // row base that will be in effect after this line's end-of-line update.
    assign last_line     = (v_cnt == CNT_W'(FRAME_LINES - 1));
    assign v_next        = last_line ? '0 : v_cnt + 1'b1;
    assign row_step      = v_cnt[0] && (v_cnt < CNT_W'(V_ACTIVE));
    assign next_row_base = last_line ? ADDR_W'(BASE_ADDR)
                         : row_step  ? row_base + ADDR_W'(WORDS_PER_ROW)
                         : row_base;

    // Requests are decided one clock early and registered onto the RAM port.
    assign h_ahead     = {1'b0, h_cnt} + (CNT_W+1)'(FETCH_LEAD + 1);
    assign word0_issue = (h_ahead == (CNT_W+1)'(LINE_CLKS));
    assign wordk_issue = (h_ahead[5:0] == 6'd0)
                      && (h_ahead < (CNT_W+1)'(WORDS_PER_ROW * WORD_CLKS));

    always_comb begin
        fetch_req  = 1'b0;
        fetch_addr = '0;
        if (word0_issue) begin
            if ((last_line ? enable : frame_en) && (v_next < CNT_W'(FETCH_LINES))) begin
                fetch_req  = 1'b1;
                fetch_addr = next_row_base;
            end
        end else if (wordk_issue && frame_en && (v_cnt < CNT_W'(FETCH_LINES))) begin
            fetch_req  = 1'b1;
            fetch_addr = row_base + ADDR_W'(h_ahead[CNT_W:6]);
        end
    end

    assign load_word = visible && (h_cnt[5:0] == 6'd0);
    assign pix_src   = load_word ? next_word : shift_reg;
    assign pix_bit   = pix_src[~h_cnt[5:1]];
    assign show      = visible && frame_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_en    <= 1'b0;
            frame_inv   <= 1'b0;
            row_base    <= ADDR_W'(BASE_ADDR);
            chipselect2 <= 1'b0;
            address2    <= '0;
            capture     <= 1'b0;
            next_word   <= '0;
            shift_reg   <= '0;
        end else begin
            if (frame_end) begin
                frame_en  <= enable;
                frame_inv <= invert;
            end
            if (line_end) row_base <= next_row_base;
            chipselect2 <= fetch_req;
            address2    <= fetch_req ? fetch_addr : '0;
            capture     <= chipselect2;
            if (capture) next_word <= readdata2;
            if (load_word) shift_reg <= next_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_hs_n    <= 1'b1;
            vga_vs_n    <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_rgb     <= '0;
            frame_start <= 1'b0;
        end else begin
            vga_hs_n    <= ~hs;
            vga_vs_n    <= ~vs;
            vga_blank_n <= show;
            vga_rgb     <= show ? ((pix_bit ^ frame_inv) ? FG_RGB : BG_RGB) : '0;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule
